// File: rtl/div_pkg.sv
// Shared widths, FSM encodings and opcode constants for the EX-stage divider.
// The sign helpers are shared by operand magnitude conversion and result correction.
package div_pkg;

    localparam int REG_BUS_W        = 32;
    localparam int DOUBLE_REG_BUS_W = 64;

    typedef logic [REG_BUS_W-1:0]        reg_bus_t;
    typedef logic [DOUBLE_REG_BUS_W-1:0] double_reg_bus_t;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [5:0] DIV_ITERATIONS = 6'd32;

    // Two's complement negation when cond is set, identity otherwise.
    function automatic reg_bus_t negate_if(input logic cond, input reg_bus_t value);
        reg_bus_t res;
        if (cond) begin
            res = ~value + 32'd1;
        end else begin
            res = value;
        end
        return res;
    endfunction

    function automatic reg_bus_t magnitude(input logic is_signed, input reg_bus_t value);
        return negate_if(is_signed & value[REG_BUS_W-1], value);
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_if;
    import div_pkg::*;

    logic            signed_div_i;
    reg_bus_t        opdata1_i;
    reg_bus_t        opdata2_i;
    logic            start_i;
    logic            annul_i;
    double_reg_bus_t result_o;
    logic            ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, {HI,LO} result
// held with ready until EX drops its start request.
module div
    import div_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    div_if.slave   div_bus
);

    div_state_e      state_r,    state_s;
    logic [5:0]      cnt_r,      cnt_s;
    logic [64:0]     dividend_r, dividend_s;
    reg_bus_t        divisor_r,  divisor_s;
    logic            neg_quot_r, neg_quot_s;
    logic            neg_rem_r,  neg_rem_s;
    double_reg_bus_t result_r,   result_s;
    logic            ready_r,    ready_s;

    logic [32:0]     diff_s;
    reg_bus_t        quot_mag_s;
    reg_bus_t        rem_mag_s;

    // Trial subtraction of the divisor magnitude from the upper partial remainder.
    assign diff_s     = {1'b0, dividend_r[63:32]} - {1'b0, divisor_r};
    assign quot_mag_s = dividend_r[31:0];
    assign rem_mag_s  = dividend_r[64:33];

    // Next-state and datapath update for the four-state divide sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        neg_quot_s = neg_quot_r;
        neg_rem_s  = neg_rem_r;
        result_s   = result_r;
        ready_s    = ready_r;

        case (state_r)
            DIV_FREE: begin
                if ((div_bus.start_i == DIV_START) && !div_bus.annul_i) begin
                    if (div_bus.opdata2_i == 32'd0) begin
                        state_s = DIV_BY_ZERO;
                    end else begin
                        state_s    = DIV_ON;
                        cnt_s      = 6'd0;
                        dividend_s = {32'd0, magnitude(div_bus.signed_div_i, div_bus.opdata1_i), 1'b0};
                        divisor_s  = magnitude(div_bus.signed_div_i, div_bus.opdata2_i);
                        neg_quot_s = div_bus.signed_div_i &
                                     (div_bus.opdata1_i[31] ^ div_bus.opdata2_i[31]);
                        neg_rem_s  = div_bus.signed_div_i & div_bus.opdata1_i[31];
                    end
                end else begin
                    state_s = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                state_s  = DIV_END;
                result_s = 64'd0;
                ready_s  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (div_bus.annul_i) begin
                    state_s = DIV_FREE;
                    cnt_s   = 6'd0;
                end else if (cnt_r != DIV_ITERATIONS) begin
                    // A borrow means the divisor did not fit: quotient bit 0, keep remainder.
                    if (diff_s[32]) begin
                        dividend_s = {dividend_r[63:0], 1'b0};
                    end else begin
                        dividend_s = {diff_s[31:0], dividend_r[31:0], 1'b1};
                    end
                    cnt_s = cnt_r + 6'd1;
                end else begin
                    state_s  = DIV_END;
                    result_s = {negate_if(neg_rem_r, rem_mag_s), negate_if(neg_quot_r, quot_mag_s)};
                    ready_s  = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                if (div_bus.start_i == DIV_STOP) begin
                    state_s  = DIV_FREE;
                    ready_s  = DIV_RESULT_NOT_READY;
                    result_s = 64'd0;
                    cnt_s    = 6'd0;
                end else begin
                    state_s = DIV_END;
                end
            end

            default: begin
                state_s  = DIV_FREE;
                cnt_s    = 6'd0;
                ready_s  = DIV_RESULT_NOT_READY;
                result_s = 64'd0;
            end
        endcase
    end

    // State and datapath registers; reset returns to FREE with outputs cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= DIV_FREE;
            cnt_r      <= 6'd0;
            dividend_r <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_r   <= 64'd0;
            ready_r    <= DIV_RESULT_NOT_READY;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            neg_quot_r <= neg_quot_s;
            neg_rem_r  <= neg_rem_s;
            result_r   <= result_s;
            ready_r    <= ready_s;
        end
    end

    assign div_bus.result_o = result_r;
    assign div_bus.ready_o  = ready_r;

endmodule
